// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller with majority sampling, parity, stop and break checks
//
// Purpose: oversampled UART receiver. Detects the start bit, recovers each bit
// by a 3-sample majority around mid-bit, deserialises 5..MAX_DW data bits,
// checks optional even/odd parity and 1 or 2 stop bits, and detects breaks.
//
// Ports:
//   CLK        oversampling clock
//   RST        synchronous active-high reset
//   RX_IN      asynchronous serial line, idle high
//   Prescale   oversampling ratio (8, 16 or 32)
//   DATA_LEN   data bits per frame, clamped to 5..MAX_DW
//   PAR_EN     parity bit present
//   PAR_TYP    0 even, 1 odd
//   STOP2      two stop bits
//   P_DATA     received word, LSB first bit, updated only with data_valid
//   data_valid one-cycle pulse, frame received correctly
//   par_err    one-cycle pulse, parity mismatch
//   stp_err    one-cycle pulse, stop bit low
//   brk_det    one-cycle pulse, break (whole frame low)
module uart_rx_frame_ctrl #(
    parameter int MAX_DW  = 9,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic [3:0]         DATA_LEN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    output logic [MAX_DW-1:0]  P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               brk_det
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_s;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic [PRESC_W-1:0] presc_l;
    logic [3:0]         dl_l;
    logic               par_en_l;
    logic               par_typ_l;
    logic               stop2_l;
    logic               s0;
    logic               s1;
    logic [MAX_DW-1:0]  shadow;
    logic               par_bit;
    logic               par_fail;
    logic               stop1_zero;
    logic               stop_idx;

    logic [PRESC_W-1:0] h;
    logic [PRESC_W-1:0] h_m1;
    logic [PRESC_W-1:0] h_p1;
    logic [PRESC_W-1:0] p_m1;
    logic               maj;
    logic               at_mid;
    logic               at_end;
    logic [3:0]         dl_clamped;
    logic               last_stop;
    logic               any_stop_zero;
    logic               all_stop_zero;
    logic               is_break;

    always_comb begin
        h      = presc_l >> 1;
        h_m1   = h - PRESC_W'(1);
        h_p1   = h + PRESC_W'(1);
        p_m1   = presc_l - PRESC_W'(1);
        // Two earlier samples are registered; the third is the live rx_s.
        maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        at_mid = (edge_cnt == h_p1);
        at_end = (edge_cnt == p_m1);

        dl_clamped = DATA_LEN;
        if (DATA_LEN < 4'd5)
            dl_clamped = 4'd5;
        else if (DATA_LEN > 4'(MAX_DW))
            dl_clamped = 4'(MAX_DW);

        last_stop     = !stop2_l || stop_idx;
        any_stop_zero = !maj || (stop2_l && stop1_zero);
        all_stop_zero = !maj && (!stop2_l || stop1_zero);
        is_break      = (shadow == '0) && (!par_en_l || !par_bit) && all_stop_zero;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            presc_l    <= '0;
            dl_l       <= 4'd5;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            stop2_l    <= 1'b0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            shadow     <= '0;
            par_bit    <= 1'b0;
            par_fail   <= 1'b0;
            stop1_zero <= 1'b0;
            stop_idx   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            brk_det    <= 1'b0;
        end else begin
            rx_meta    <= RX_IN;
            rx_s       <= rx_meta;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            brk_det    <= 1'b0;

            if (edge_cnt == h_m1) s0 <= rx_s;
            if (edge_cnt == h)    s1 <= rx_s;

            // Edge counter free-runs per bit in the active states.
            if (state == START || state == DATA || state == PAR || state == STOP)
                edge_cnt <= at_end ? '0 : edge_cnt + PRESC_W'(1);

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        presc_l    <= Prescale;
                        dl_l       <= dl_clamped;
                        par_en_l   <= PAR_EN;
                        par_typ_l  <= PAR_TYP;
                        stop2_l    <= STOP2;
                        shadow     <= '0;
                        par_bit    <= 1'b0;
                        par_fail   <= 1'b0;
                        stop1_zero <= 1'b0;
                        stop_idx   <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (at_mid && maj) begin
                        edge_cnt <= '0;
                        state    <= IDLE;
                    end else if (at_end) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (at_mid) begin
                        for (int i = 0; i < MAX_DW; i++)
                            if (4'(i) == bit_cnt) shadow[i] <= maj;
                    end
                    if (at_end) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == dl_l - 4'd1)
                            state <= par_en_l ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (at_mid) begin
                        par_bit  <= maj;
                        par_fail <= (((^shadow) ^ maj) != par_typ_l);
                    end
                    if (at_end) state <= STOP;
                end
                STOP: begin
                    if (at_mid && !last_stop) begin
                        stop1_zero <= !maj;
                    end else if (at_mid) begin
                        // Leave at mid-stop so the next falling edge is caught.
                        edge_cnt <= '0;
                        state    <= IDLE;
                        if (is_break) begin
                            brk_det <= 1'b1;
                            state   <= BRK;
                        end else if (any_stop_zero) begin
                            stp_err <= 1'b1;
                        end else if (par_fail) begin
                            par_err <= 1'b1;
                        end else begin
                            P_DATA     <= shadow;
                            data_valid <= 1'b1;
                        end
                    end
                    if (at_end && !last_stop) stop_idx <= 1'b1;
                end
                BRK: begin
                    edge_cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
